// File: rtl/int_mac_pipe.sv
// Three-stage signed multiply-accumulate: P = C +/- A*B, or P = P +/- A*B when ACCUM=1.
// Optional saturation on overflow is built when INT_MAC_SAT_EN is defined; otherwise P wraps.
module int_mac_pipe #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int C_WIDTH = 64,
  parameter int P_WIDTH = 64
) (
  input  logic                 CLK,
  input  logic                 SCLR,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [B_WIDTH-1:0]   B,
  input  logic [C_WIDTH-1:0]   C,
  input  logic                 SUBTRACT,
  input  logic                 ACCUM,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [P_WIDTH-1:0]   P,
  output logic                 OVF,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
);

  localparam int PROD_W = A_WIDTH + B_WIDTH;

  logic en;

  logic               s1_valid;
  logic [A_WIDTH-1:0] s1_a;
  logic [B_WIDTH-1:0] s1_b;
  logic [C_WIDTH-1:0] s1_c;
  logic               s1_sub;
  logic               s1_acc;

  logic               s2_valid;
  logic [PROD_W-1:0]  s2_prod;
  logic [C_WIDTH-1:0] s2_c;
  logic               s2_sub;
  logic               s2_acc;

  logic [PROD_W-1:0]  a_ext;
  logic [PROD_W-1:0]  b_ext;
  logic [P_WIDTH:0]   addend_x;
  logic [P_WIDTH:0]   prod_x;
  logic [P_WIDTH:0]   sum;
  logic               sum_ovf;
  logic [P_WIDTH-1:0] p_next;

  // The whole pipe moves as one; a held result freezes every stage behind it.
  assign en       = !OUT_VALID | OUT_READY;
  assign IN_READY = en & !SCLR;

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= IN_VALID;
      s1_a     <= A;
      s1_b     <= B;
      s1_c     <= C;
      s1_sub   <= SUBTRACT;
      s1_acc   <= ACCUM;
    end
  end

  // Sign-extending both operands to the product width lets a plain multiply
  // give the exact signed product in its low PROD_W bits.
  assign a_ext = {{B_WIDTH{s1_a[A_WIDTH-1]}}, s1_a};
  assign b_ext = {{A_WIDTH{s1_b[B_WIDTH-1]}}, s1_b};

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_prod  <= a_ext * b_ext;
      s2_c     <= s1_c;
      s2_sub   <= s1_sub;
      s2_acc   <= s1_acc;
    end
  end

  // One guard bit above P_WIDTH exposes signed overflow as a top-two-bit mismatch.
  assign addend_x = s2_acc ? {P[P_WIDTH-1], P}
                           : {{(P_WIDTH + 1 - C_WIDTH){s2_c[C_WIDTH-1]}}, s2_c};
  assign prod_x   = {{(P_WIDTH + 1 - PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
  assign sum      = s2_sub ? (addend_x - prod_x) : (addend_x + prod_x);
  assign sum_ovf  = sum[P_WIDTH] ^ sum[P_WIDTH-1];

`ifdef INT_MAC_SAT_EN
  always_comb begin
    p_next = sum[P_WIDTH-1:0];
    if (sum_ovf) begin
      p_next = sum[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                            : {1'b0, {(P_WIDTH-1){1'b1}}};
    end
  end
`else
  assign p_next = sum[P_WIDTH-1:0];
`endif

  // P doubles as the accumulator, so a bubble must leave it untouched.
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      OUT_VALID <= 1'b0;
      P         <= '0;
      OVF       <= 1'b0;
    end else if (en) begin
      OUT_VALID <= s2_valid;
      if (s2_valid) begin
        P   <= p_next;
        OVF <= sum_ovf;
      end
    end
  end

endmodule

// File: tb/tb_int_mac_pipe.sv
// Self-checking bench for int_mac_pipe: a reference model fills a scoreboard at
// acceptance and every consumed result is compared, plus directed timing checks.
module tb_int_mac_pipe;

  logic        CLK;
  logic        SCLR;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] C;
  logic        SUBTRACT;
  logic        ACCUM;
  logic        IN_VALID;
  logic        IN_READY;
  logic [63:0] P;
  logic        OVF;
  logic        OUT_VALID;
  logic        OUT_READY;

  int_mac_pipe #(
    .A_WIDTH(32), .B_WIDTH(32), .C_WIDTH(64), .P_WIDTH(64)
  ) dut (
    .CLK(CLK), .SCLR(SCLR), .A(A), .B(B), .C(C), .SUBTRACT(SUBTRACT),
    .ACCUM(ACCUM), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .P(P),
    .OVF(OVF), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] p;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model_p;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] c, input logic sub, input logic acc);
    longint      prod;
    logic [64:0] addx, prodx, s;
    exp_t        r;
    prod  = longint'($signed(a)) * longint'($signed(b));
    prodx = {prod[63], prod};
    addx  = acc ? {model_p[63], model_p} : {c[63], c};
    s     = sub ? addx - prodx : addx + prodx;
    r.ovf = s[64] ^ s[63];
    r.p   = s[63:0];
`ifdef INT_MAC_SAT_EN
    if (r.ovf) r.p = s[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return r;
  endfunction

  // Handshakes are evaluated mid-cycle; they describe what the next rising edge does.
  always @(negedge CLK) begin
    exp_t e;
    if (SCLR) begin
      sb_q.delete();
      model_p = '0;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 64'(OUT_VALID), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_p", P, e.p);
          chk("sb_ovf", 64'(OVF), 64'(e.ovf));
        end
      end
      if (IN_VALID && IN_READY) begin
        e = model(A, B, C, SUBTRACT, ACCUM);
        model_p = e.p;
        sb_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] c,
                      input logic sub, input logic acc);
    A = a; B = b; C = c; SUBTRACT = sub; ACCUM = acc; IN_VALID = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (IN_READY) begin
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        return;
      end
      @(posedge CLK); #1;
    end
    chk("send_timeout", 64'd0, 64'd1);
    IN_VALID = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) cyc(1);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    bit          seen;
    n_chk = 0; n_pass = 0; model_p = '0;
    SCLR = 1'b1; A = '0; B = '0; C = '0; SUBTRACT = 1'b0; ACCUM = 1'b0;
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("ready_in_reset", 64'(IN_READY), 64'd0);
    @(posedge CLK); #1;
    IN_VALID = 1'b0; SCLR = 1'b0;
    chk("rst_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_p", P, 64'd0);
    chk("rst_ovf", 64'(OVF), 64'd0);

    // basic latency: valid exactly three cycles after the accepting edge
    send(32'd3, 32'd5, 64'd10, 1'b0, 1'b0);
    cyc(1);
    chk("lat_early", 64'(OUT_VALID), 64'd0);
    cyc(1);
    chk("lat_valid", 64'(OUT_VALID), 64'd1);
    chk("basic_p", P, 64'd25);
    chk("basic_ovf", 64'(OVF), 64'd0);

    send(-32'sd2, 32'd7, 64'd100, 1'b1, 1'b0);
    cyc(2);
    chk("sub_p", P, 64'd114);
    drain();

    // back-to-back accumulate chain
    send(32'd2, 32'd3, 64'd1, 1'b0, 1'b0);
    send(32'd4, 32'd5, 64'd0, 1'b0, 1'b1);
    send(-32'sd1, 32'd1, 64'd0, 1'b0, 1'b1);
    chk("chain_v0", 64'(OUT_VALID), 64'd1);
    chk("chain_p0", P, 64'd7);
    cyc(1);
    chk("chain_v1", 64'(OUT_VALID), 64'd1);
    chk("chain_p1", P, 64'd27);
    cyc(1);
    chk("chain_v2", 64'(OUT_VALID), 64'd1);
    chk("chain_p2", P, 64'd26);
    drain();

    // positive overflow, then negative overflow
    send(32'd1, 32'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    cyc(2);
`ifdef INT_MAC_SAT_EN
    chk("ovf_pos_p", P, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    chk("ovf_pos_p", P, 64'h8000_0000_0000_0000);
`endif
    chk("ovf_pos_flag", 64'(OVF), 64'd1);
    send(32'd1, 32'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    cyc(2);
`ifdef INT_MAC_SAT_EN
    chk("ovf_neg_p", P, 64'h8000_0000_0000_0000);
`else
    chk("ovf_neg_p", P, 64'h7FFF_FFFF_FFFF_FFFF);
`endif
    chk("ovf_neg_flag", 64'(OVF), 64'd1);
    send(32'd3, 32'd1, 64'd0, 1'b0, 1'b1);
    drain();

    // backpressure: six beats offered while the consumer stalls for five cycles
    OUT_READY = 1'b0;
    seen = 1'b0;
    held = '0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send($urandom, $urandom, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge CLK);
          if (OUT_VALID) begin
            if (!seen) begin held = P; seen = 1'b1; end
            chk("stall_in_ready", 64'(IN_READY), 64'd0);
            chk("stall_p_hold", P, held);
          end
        end
        chk("stall_seen", 64'(seen), 64'd1);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
      end
    join
    drain();

    // random traffic with a toggling consumer
    fork
      begin
        for (int i = 0; i < 20; i++)
          send($urandom, $urandom, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          OUT_READY = 1'($urandom_range(0, 1));
          cyc(1);
        end
        OUT_READY = 1'b1;
      end
    join
    OUT_READY = 1'b1;
    drain();

    // reset with two beats in flight
    send(32'd5, 32'd5, 64'd0, 1'b0, 1'b0);
    drain();
    send(32'd9, 32'd9, 64'd1, 1'b0, 1'b0);
    send(32'd7, 32'd7, 64'd2, 1'b0, 1'b1);
    SCLR = 1'b1;
    cyc(1);
    SCLR = 1'b0;
    chk("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    chk("mid_rst_p", P, 64'd0);
    chk("mid_rst_ovf", 64'(OVF), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      if (OUT_VALID) seen = 1'b1;
    end
    chk("mid_rst_no_ghost", 64'(seen), 64'd0);
    send(32'd2, 32'd2, 64'd0, 1'b0, 1'b1);
    cyc(2);
    chk("post_rst_acc", P, 64'd4);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/int_mac_pipe.md
# int_mac_pipe

Parametrised, pipelined signed integer multiply-accumulate unit computing P = C ± A×B, or P = P_prev ± A×B in accumulate mode. It is the in-house successor to the fixed-width multiply-adder. It adds:
- configurable operand/result widths,
- a valid/ready handshake with backpressure,
- a running-accumulate mode,
- an overflow flag, with optional saturation.

It sits between operand-fetch logic and result writeback in the lab datapath.

## Interface
Parameters:
- A_WIDTH, 32, signed width of A
- B_WIDTH, 32, signed width of B
- C_WIDTH, 64, signed width of C; must be ≤ P_WIDTH
- P_WIDTH, 64, result width; must be ≥ A_WIDTH+B_WIDTH

Ports:
- CLK  in  1  clock, all state on rising edge
- SCLR  in  1  synchronous active-high reset
- A  in  A_WIDTH  multiplicand, two's complement
- B  in  B_WIDTH  multiplier, two's complement
- C  in  C_WIDTH  addend, two's complement; ignored when ACCUM=1
- SUBTRACT  in  1  0: addend + A×B; 1: addend − A×B
- ACCUM  in  1  0: addend is C; 1: addend is current P register
- IN_VALID  in  1  operand beat offered
- IN_READY  out  1  beat accepted on edge where IN_VALID & IN_READY
- P  out  P_WIDTH  result
- OVF  out  1  signed overflow occurred computing this P
- OUT_VALID  out  1  P/OVF hold a result
- OUT_READY  in  1  consumer takes result on edge where OUT_VALID & OUT_READY

Clocking and reset are fixed: one clock, CLK; reset is synchronous and active-high, SCLR.

## Operation
- Three register stages, each with a valid bit:
  - S1: registers A, B, C, SUBTRACT, ACCUM.
  - S2: registers the full product, width A_WIDTH+B_WIDTH, signed.
  - S3: P/OVF register, which is also the accumulator.
- Global advance enable: EN = !OUT_VALID | OUT_READY. All stages shift together when EN=1 and hold when EN=0. Intermediate bubbles are not collapsed.
- IN_READY = EN & !SCLR.
- Arithmetic:
  - Product and C are sign-extended to P_WIDTH+1.
  - Sum = addend ± product is computed at P_WIDTH+1 bits.
  - OVF = 1 when the top two bits of the sum differ.
- ACCUM=1:
  - The addend is the P register value at the edge S3 loads this beat.
  - That is the last completed result, whether or not it was consumed.
  - Back-to-back ACCUM beats therefore chain correctly with no hazard.
- After reset, P=0, so a first ACCUM beat accumulates from 0.
- Bubble entering S3 (S2 valid=0 while EN=1): OUT_VALID←0; P and OVF hold their values.
- Results emerge in acceptance order. No beat is dropped or duplicated under any OUT_READY pattern.

## Timing
- Reset (SCLR=1 at an edge):
  - All valid bits ←0, P←0, OVF←0.
  - IN_READY=0 while SCLR=1.
  - In-flight beats are discarded and never appear at the output.
  - SCLR has priority over any simultaneous accept or consume.
- Latency: a beat accepted at the end of cycle t appears with OUT_VALID=1 in cycle t+3, provided EN=1 throughout.
- Throughput: 1 beat/cycle while OUT_READY=1.
- Stall: OUT_VALID=1 & OUT_READY=0 makes EN=0 and IN_READY=0 in the same cycle. All stages, P and OVF hold.
- Simultaneous consume and produce (OUT_READY=1, S2 valid): P updates to the next result on that edge; OUT_VALID stays 1.
- P, OVF and OUT_VALID are registered outputs. IN_READY is combinational from OUT_VALID, OUT_READY and SCLR.

## Configuration
- INT_MAC_SAT_EN defined:
  - On overflow, P is clamped to the signed P_WIDTH limits: 0x7FF…F for positive overflow, 0x800…0 for negative overflow.
  - OVF=1 on that result.
  - The clamped value is the accumulator for subsequent ACCUM beats.
- INT_MAC_SAT_EN undefined:
  - P wraps modulo 2^P_WIDTH.
  - OVF is still reported.

## Test plan
- Basic, default params: A=3, B=5, C=10, SUBTRACT=0 → P=25, OVF=0, exactly 3 cycles after accept.
- Subtract: A=−2, B=7, C=100, SUBTRACT=1 → P=114.
- Accumulate chain, back-to-back:
  - (2, 3, C=1, ACCUM=0) → 7
  - (4, 5, ACCUM=1) → 27
  - (−1, 1, ACCUM=1) → 26
  - Three consecutive OUT_VALID cycles.
- Overflow: C=0x7FFF_FFFF_FFFF_FFFF, A=1, B=1, SUBTRACT=0:
  - Without macro → P=0x8000_0000_0000_0000, OVF=1.
  - With INT_MAC_SAT_EN → P=0x7FFF_FFFF_FFFF_FFFF, OVF=1.
- Backpressure: offer 6 beats continuously while OUT_READY=0 for 5 cycles, then 1:
  - IN_READY drops once OUT_VALID rises.
  - All 6 results are delivered in order, with no loss or duplication.
  - P is stable during the stall.
- Reset mid-flight: accept 2 beats, assert SCLR one cycle later →
  - Next cycle: OUT_VALID=0, P=0, OVF=0.
  - Neither beat ever appears.
  - The next accepted ACCUM beat (A=2, B=2) → P=4.
